// File: rtl/conv_window_gen.sv
// 5x5 sliding-window generator: raster pixels in, one registered 5x5 window per valid position out.
// Optional macro CONV_WINDOW_GEN_WINCNT_EN adds the win_cnt handshake counter output.
module conv_window_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic [199:0] win_out,
    output logic         win_valid,
    input  logic         win_ready,
    output logic         win_last,
    output logic         busy,
`ifdef CONV_WINDOW_GEN_WINCNT_EN
    output logic [15:0]  win_cnt,
`endif
    output logic         done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(4);
    localparam logic [RW-1:0] ROW_WIN  = RW'(4);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          acc, win_hs, win_load, last_pix;
    logic [7:0]    lb [4][IMG_W];
    logic [7:0]    col_new [5];
    logic [7:0]    shift_p0 [5][5];

    assign pix_ready = (state == RUN) && (!win_valid || win_ready);
    assign busy      = (state != IDLE);
    assign acc       = pix_valid && pix_ready;
    assign win_hs    = win_valid && win_ready;
    assign win_load  = acc && (row >= ROW_WIN) && (col >= COL_WIN);
    assign last_pix  = acc && (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_pix) state_nx = DRAIN;
            DRAIN:   if (win_hs && win_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers hold rows r-1..r-4 at the current column; a pixel pushes the column down one row.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb[0][col] <= pix_in;
            for (int k = 1; k < 4; k++) lb[k][col] <= lb[k-1][col];
        end
    end

    always_comb begin
        col_new[4] = pix_in;
        for (int k = 0; k < 4; k++) col_new[3-k] = lb[k][col];
    end

    // Stage p0: the shift array is the registered window itself; it only moves on a pixel accept,
    // and pixels are refused while a window is stalled, so win_out holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) shift_p0[r][c] <= '0;
        end else if (acc) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) shift_p0[r][c] <= shift_p0[r][c+1];
                shift_p0[r][4] <= col_new[r];
            end
        end
    end

    always_comb begin
        win_out = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) win_out[8*(5*r+c) +: 8] = shift_p0[r][c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && win_hs && win_last;
            if (win_load) begin
                win_valid <= 1'b1;
                win_last  <= last_pix;
            end else if (win_hs) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

`ifdef CONV_WINDOW_GEN_WINCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        win_cnt <= '0;
        else if (state == IDLE && start) win_cnt <= '0;
        else if (win_hs)                win_cnt <= win_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: windows are predicted from the image array and popped by a monitor.
module tb_conv_window_gen;
    localparam int W    = 32;
    localparam int H    = 32;
    localparam int NWIN = (W - 4) * (H - 4);

    logic         clk = 1'b0;
    logic         rst, start, pix_valid, win_ready;
    logic [7:0]   pix_in;
    logic         pix_ready, win_valid, win_last, busy, done;
    logic [199:0] win_out;
`ifdef CONV_WINDOW_GEN_WINCNT_EN
    logic [15:0]  win_cnt;
`endif

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready),
        .win_last(win_last), .busy(busy),
`ifdef CONV_WINDOW_GEN_WINCNT_EN
        .win_cnt(win_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [199:0] w;
        logic         last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] img [H][W];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         win_seen = 0;
    int         ready_mode = 0;
    bit         frame_done = 0;
    bit         last_hs_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: every stride-1 5x5 patch of the image, in raster order of its bottom-right pixel.
    task automatic load_frame(input bit pattern);
        exp_t e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = pattern ? 8'((32 * r + c) % 256) : 8'($urandom);
        exp_q.delete();
        for (int r = 4; r < H; r++) begin
            for (int c = 4; c < W; c++) begin
                e.w = '0;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        e.w[8*(5*i+j) +: 8] = img[r-4+i][c-4+j];
                e.last = (r == H - 1) && (c == W - 1);
                exp_q.push_back(e);
            end
        end
        win_seen   = 0;
        frame_done = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic stream(input int n_pix, input int start_at, input bit gaps, input bit check_first);
        int k = 0;
        int guard = 0;
        bit accepted;
        bit sent = 0;
        while (k < n_pix && guard < 20000) begin
            pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_in    = pix_valid ? img[k / W][k % W] : 8'($urandom);
            if (k == start_at && !sent) begin
                start = 1'b1;
                sent  = 1'b1;
            end
            @(negedge clk);
            accepted = pix_valid && pix_ready;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (accepted) begin
                if (check_first && k == 4 * W + 4) begin
                    check("first_win_latency", 32'(win_valid), 32'd1);
                    check("first_byte0", 32'(win_out[7:0]), 32'd0);
                    check("first_byte4", 32'(win_out[39:32]), 32'd4);
                    check("first_byte20", 32'(win_out[167:160]), 32'd128);
                    check("first_byte24", 32'(win_out[199:192]), 32'd132);
                end
                k++;
            end
        end
        pix_valid = 1'b0;
        if (k < n_pix) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: got %0d pixels, expected %0d", k, n_pix);
        end
    endtask

    task automatic wait_frame();
        int g = 0;
        while (!frame_done && g < 5000) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (!frame_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: got %0d windows, expected done after %0d", win_seen, NWIN);
        end
        check("window_count", 32'(win_seen), 32'(NWIN));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: sample at the falling edge, where a window handshake for the next rising edge is settled.
    always @(negedge clk) begin
        if (rst) begin
            last_hs_prev = 1'b0;
        end else begin
            if (last_hs_prev) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_after_done", 32'(busy), 32'd0);
`ifdef CONV_WINDOW_GEN_WINCNT_EN
                check("win_cnt_at_done", 32'(win_cnt), 32'(NWIN));
`endif
                frame_done = 1'b1;
            end
            last_hs_prev = 1'b0;
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_window: got window %0d, expected none", win_seen);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_win("win_out", win_out, e.w);
                    check("win_last", 32'(win_last), 32'(e.last));
                end
                win_seen++;
                last_hs_prev = win_last;
            end
        end
    end

    // Consumer: always ready, random ready, or a single 10-cycle stall part-way through the frame.
    initial begin
        logic [199:0] held;
        win_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1: win_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (win_valid && win_seen >= 50) begin
                        held      = win_out;
                        win_ready = 1'b0;
                        repeat (10) begin
                            @(negedge clk);
                            check("stall_pix_ready", 32'(pix_ready), 32'd0);
                            check("stall_win_valid", 32'(win_valid), 32'd1);
                            check_win("stall_win_out", win_out, held);
                            @(posedge clk); #1;
                        end
                        win_ready  = 1'b1;
                        ready_mode = 1;
                    end else begin
                        win_ready = 1'b1;
                    end
                end
                default: win_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_win("rst_win_out", win_out, 200'd0);
        check("rst_win_valid", 32'(win_valid), 32'd0);
        check("rst_win_last", 32'(win_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Counting pattern, continuous stream, consumer always ready.
        load_frame(1'b1);
        ready_mode = 0;
        pulse_start();
        stream(W * H, -1, 1'b0, 1'b1);
        wait_frame();

        // Random pixels with input gaps and a 10-cycle consumer stall.
        load_frame(1'b0);
        ready_mode = 2;
        pulse_start();
        stream(W * H, -1, 1'b1, 1'b0);
        wait_frame();

        // Reset after 300 pixels, then a full random frame.
        load_frame(1'b0);
        ready_mode = 1;
        pulse_start();
        stream(300, -1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_win("midrst_win_out", win_out, 200'd0);
        check("midrst_win_valid", 32'(win_valid), 32'd0);
        check("midrst_win_last", 32'(win_last), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pix_ready", 32'(pix_ready), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("no_win_after_rst", 32'(win_valid), 32'd0);
            check("idle_after_rst", 32'(busy), 32'd0);
        end
        load_frame(1'b0);
        pulse_start();
        stream(W * H, -1, 1'b1, 1'b0);
        wait_frame();

        // Start pulsed while running must not disturb the frame.
        load_frame(1'b1);
        ready_mode = 0;
        pulse_start();
        stream(W * H, 100, 1'b0, 1'b0);
        wait_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 32, meaning input image width in pixels (5..1024).
REQ-002 SHALL have parameter IMG_H, default 32, meaning input image height in pixels (5..1024).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle frame start request.
REQ-006 SHALL have port pix_in  input  8  unsigned raster pixel, row-major order.
REQ-007 SHALL have port pix_valid  input  1  pix_in valid.
REQ-008 SHALL have port pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
REQ-009 SHALL have port win_out  output  200  5x5 window, byte i = bits [8i+7:8i], i = 5*r + c; r=0 is the top row, c=0 is the left column; the bus maps directly to PE feature inputs 1..25.
REQ-010 SHALL have port win_valid  output  1  win_out valid.
REQ-011 SHALL have port win_ready  input  1  window consumed when win_valid && win_ready.
REQ-012 SHALL have port win_last  output  1  high with the final window of the frame.
REQ-013 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final window is consumed.

Function
REQ-015 SHALL implement states IDLE, RUN and DRAIN.
- IDLE -> RUN on start.
- RUN -> DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1).
- DRAIN -> IDLE on the handshake of the win_last window, with done pulsed in that transition cycle.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL hold pix_ready low in IDLE and DRAIN. In RUN, pix_ready = !win_valid || win_ready.
REQ-018 SHALL keep four line buffers of IMG_W bytes (rows r-1..r-4) plus a 5x5 byte shift array, both advancing only on a pixel handshake.
REQ-019 SHALL track pixel column and row counters:
- column wraps IMG_W-1 -> 0 and increments row;
- row clears on start.
REQ-020 SHALL produce a window only when an accepted pixel has row >= 4 and column >= 4. This is stride 1 with no padding, giving (IMG_W-4)*(IMG_H-4) windows per frame.
REQ-021 SHALL assert win_valid on the cycle after the handshake of the window's bottom-right pixel (latency 1), with win_out registered.
REQ-022 SHALL hold win_out and win_last stable while win_valid && !win_ready.
REQ-023 SHALL deassert win_valid after the handshake unless a new window is loaded in the same cycle. Simultaneous window handshake and window-completing pixel handshake SHALL give back-to-back windows with no bubble.
REQ-024 SHALL not use windows spanning the row wrap: line-buffer columns 0..3 of each row only fill the shift array.
REQ-025 SHALL assert win_last only with the window whose bottom-right pixel is (IMG_H-1, IMG_W-1).
REQ-026 SHALL ignore pix_valid when pix_ready is low, and SHALL not treat pix_in X values as accepted.

Reset
REQ-027 SHALL on rst force:
- state IDLE;
- counters 0;
- win_out 0;
- win_valid, win_last, done, busy and pix_ready all 0.
REQ-028 SHALL let reset mid-frame discard the partial frame with no further window. Line-buffer contents need no reset, because REQ-024 guarantees only written data is used.

Configuration
REQ-029 SHALL, when macro CONV_WINDOW_GEN_WINCNT_EN is defined, add output win_cnt (16 bits, reset 0, cleared on start) that increments on each window handshake. Without the macro the port and counter SHALL not exist and behaviour is otherwise identical.

Verification
REQ-030 SHALL test first window: 32x32 frame, pixel = (32r+c) mod 256, win_ready=1 -> first win_valid one cycle after pixel (4,4) accepted; byte0=0, byte4=4, byte20=128, byte24=132.
REQ-031 SHALL test frame count: the same frame streamed continuously -> exactly 784 windows, win_last only on the 784th (byte24=(32*31+31) mod 256=255), done one cycle later, busy low after.
REQ-032 SHALL test backpressure: win_ready held low 10 cycles while win_valid -> pix_ready low, win_out unchanged all 10 cycles; on release the next window follows with no loss or duplication.
REQ-033 SHALL test reset mid-frame: rst asserted after 300 pixels -> outputs 0 that cycle, state IDLE; a new start then streams a full frame -> 784 correct windows.
REQ-034 SHALL test start ignored: start pulsed in RUN at pixel 100 -> counters unaffected, frame completes with 784 windows; with CONV_WINDOW_GEN_WINCNT_EN, win_cnt=784 at done.
